// File: rtl/image_ram_writer.sv
// Streams 8-bit grayscale pixels into the 64x64 1-bit image RAM in raster order.
// Define IMAGE_RAM_CLEAR_EN to add a clear_req-driven pass that zeroes the whole RAM.
module image_ram_writer #(
  parameter int ADDR_W = 12,
  parameter int PIXELS = 4096,
  parameter int THRESH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_sof,
  output logic [ADDR_W-1:0] wraddress,
  output logic              data,
  output logic              wren,
  output logic              busy,
  output logic              frame_done,
  output logic              sof_err,
  input  logic              clear_req
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
`ifdef IMAGE_RAM_CLEAR_EN
    , ST_CLEAR = 2'd3
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [7:0]        THRESH_B  = 8'(THRESH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
  logic                data_q, data_d;
  logic                wren_q, wren_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                sof_err_q, sof_err_d;
  logic                ready_c;
  logic                beat_c;

  function automatic logic to_bit(input logic [7:0] px);
    return (px >= THRESH_B);
  endfunction

`ifndef IMAGE_RAM_CLEAR_EN
  logic unused_clear;
  assign unused_clear = clear_req;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wraddress_d  = wraddress_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    sof_err_d    = 1'b0;
    ready_c      = 1'b0;
    beat_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
`ifdef IMAGE_RAM_CLEAR_EN
        // A clear request pre-empts any pixel offered in the same cycle.
        ready_c = ~clear_req;
        beat_c  = s_valid & ready_c;
        if (clear_req) begin
          state_d     = ST_CLEAR;
          wraddress_d = '0;
          data_d      = 1'b0;
          wren_d      = 1'b1;
          ptr_d       = ADDR_W'(1);
        end else if (beat_c && s_sof) begin
          state_d     = ST_WRITE;
          wraddress_d = '0;
          data_d      = to_bit(s_data);
          wren_d      = 1'b1;
          ptr_d       = ADDR_W'(1);
        end
`else
        ready_c = 1'b1;
        beat_c  = s_valid;
        if (beat_c && s_sof) begin
          state_d     = ST_WRITE;
          wraddress_d = '0;
          data_d      = to_bit(s_data);
          wren_d      = 1'b1;
          ptr_d       = ADDR_W'(1);
        end
`endif
      end

      ST_WRITE: begin
        ready_c = 1'b1;
        beat_c  = s_valid;
        if (beat_c) begin
          wren_d = 1'b1;
          data_d = to_bit(s_data);
          if (s_sof) begin
            // Early start of frame: restart the raster from address 0.
            wraddress_d = '0;
            ptr_d       = ADDR_W'(1);
            sof_err_d   = 1'b1;
          end else begin
            wraddress_d = ptr_q;
            if (ptr_q == LAST_ADDR) begin
              state_d = ST_DONE;
            end else begin
              ptr_d = ptr_q + ADDR_W'(1);
            end
          end
        end
      end

      ST_DONE: begin
        ready_c = 1'b0;
        ptr_d   = '0;
        state_d = ST_IDLE;
      end

`ifdef IMAGE_RAM_CLEAR_EN
      ST_CLEAR: begin
        ready_c     = 1'b0;
        wren_d      = 1'b1;
        data_d      = 1'b0;
        wraddress_d = ptr_q;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      wraddress_q  <= '0;
      data_q       <= 1'b0;
      wren_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wraddress_q  <= wraddress_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

  assign s_ready    = ready_c;
  assign wraddress  = wraddress_q;
  assign data       = data_q;
  assign wren       = wren_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_image_ram_writer.sv
// Scoreboard bench for image_ram_writer: every accepted beat pushes its expected RAM write,
// and a negedge monitor pops and compares each wren cycle.
module tb_image_ram_writer;
  localparam int ADDR_W = 12;
  localparam int PIXELS = 4096;
  localparam int THRESH = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_sof;
  logic [ADDR_W-1:0] wraddress;
  logic              data;
  logic              wren;
  logic              busy;
  logic              frame_done;
  logic              sof_err;
  logic              clear_req;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              d;
    logic              fd;
    logic              se;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks   = 0;
  int  n_errors   = 0;
  int  m_ptr      = 0;
  bit  m_inframe  = 1'b0;
  bit  m_bubble   = 1'b0;
  int  exp_frames = 0;
  int  got_frames = 0;
  bit  mon_en     = 1'b0;

  always #20 clk = ~clk;

  image_ram_writer #(.ADDR_W(ADDR_W), .PIXELS(PIXELS), .THRESH(THRESH)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .wraddress  (wraddress),
    .data       (data),
    .wren       (wren),
    .busy       (busy),
    .frame_done (frame_done),
    .sof_err    (sof_err),
    .clear_req  (clear_req)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model of one accepted beat.
  function automatic void model_beat(input logic [7:0] d, input bit sof);
    wr_t e;
    e.d  = (d >= 8'(THRESH));
    e.fd = 1'b0;
    e.se = 1'b0;
    if (sof) begin
      e.addr    = '0;
      e.se      = m_inframe;
      m_ptr     = 1;
      m_inframe = 1'b1;
      exp_q.push_back(e);
    end else if (m_inframe) begin
      e.addr = ADDR_W'(m_ptr);
      if (m_ptr == PIXELS - 1) begin
        e.fd      = 1'b1;
        m_inframe = 1'b0;
        m_ptr     = 0;
        m_bubble  = 1'b1;
        exp_frames++;
      end else begin
        m_ptr++;
      end
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (wren) begin
        check_val("write_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_val("wraddress", 32'(wraddress), 32'(mon_e.addr));
          check_val("data", 32'(data), 32'(mon_e.d));
          check_val("frame_done", 32'(frame_done), 32'(mon_e.fd));
          check_val("sof_err", 32'(sof_err), 32'(mon_e.se));
        end
        if (frame_done) got_frames++;
      end else begin
        check_val("frame_done_idle", 32'(frame_done), 32'd0);
        check_val("sof_err_idle", 32'(sof_err), 32'd0);
      end
    end
  end

  task automatic drive_cycle(input bit v, input logic [7:0] d, input bit sof, output bit acc);
    s_valid = v;
    s_data  = d;
    s_sof   = sof;
    @(negedge clk);
    check_val("s_ready", 32'(s_ready), 32'(!m_bubble));
    acc = v && s_ready;
    @(posedge clk);
    m_bubble = 1'b0;
    if (acc) model_beat(d, sof);
    #1;
  endtask

  task automatic gap();
    bit a;
    drive_cycle(1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic send_pixel(input logic [7:0] d, input bit sof);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 4) begin
      drive_cycle(1'b1, d, sof, acc);
      tries++;
    end
    if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_sof     = 1'b0;
    s_data    = 8'h00;
    clear_req = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_wren", 32'(wren), 32'd0);
    check_val("rst_wraddress", 32'(wraddress), 32'd0);
    check_val("rst_data", 32'(data), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_sof_err", 32'(sof_err), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    m_ptr     = 0;
    m_inframe = 1'b0;
    m_bubble  = 1'b0;
    mon_en    = 1'b1;
  endtask

  initial begin
    bit a;
    do_reset();

    // Frame 1: alternating black/white.
    for (int i = 0; i < PIXELS; i++) send_pixel((i % 2 == 1) ? 8'hFF : 8'h00, i == 0);
    check_val("done_busy", 32'(busy), 32'd1);
    check_val("done_frame_done", 32'(frame_done), 32'd1);
    check_val("done_wraddress", 32'(wraddress), 32'(PIXELS - 1));
    gap();
    check_val("idle_busy", 32'(busy), 32'd0);

    // Beats without start-of-frame are discarded in IDLE.
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'hFF, 1'b0, a);
    s_valid = 1'b0;
    check_val("nosof_busy", 32'(busy), 32'd0);

    // Frame 2: valid every other cycle, threshold edges first, ends back-to-back into frame 3.
    for (int i = 0; i < PIXELS; i++) begin
      logic [7:0] px;
      case (i)
        0:       px = 8'd127;
        1:       px = 8'd128;
        2:       px = 8'd255;
        default: px = 8'($urandom);
      endcase
      send_pixel(px, i == 0);
      if (i != PIXELS - 1) gap();
    end

    // Frame 3: restart at ptr=100, then a complete frame from the restart.
    for (int i = 0; i < 100; i++) send_pixel(8'($urandom), i == 0);
    send_pixel(8'hC0, 1'b1);
    for (int i = 1; i < PIXELS; i++) send_pixel(8'($urandom), 1'b0);
    gap();
    check_val("f3_busy", 32'(busy), 32'd0);

`ifdef IMAGE_RAM_CLEAR_EN
    // Clear wins over a simultaneous start-of-frame beat.
    clear_req = 1'b1;
    s_valid   = 1'b1;
    s_sof     = 1'b1;
    s_data    = 8'hFF;
    @(negedge clk);
    check_val("clr_ready_req", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    s_valid   = 1'b0;
    s_sof     = 1'b0;
    for (int i = 0; i < PIXELS; i++) begin
      wr_t e;
      e.addr = ADDR_W'(i);
      e.d    = 1'b0;
      e.fd   = (i == PIXELS - 1);
      e.se   = 1'b0;
      exp_q.push_back(e);
    end
    exp_frames++;
    for (int i = 0; i < PIXELS; i++) begin
      @(negedge clk);
      check_val("clr_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check_val("clr_end_busy", 32'(busy), 32'd0);
    // Reset in the middle of a clear pass.
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_val("clr_mid_busy", 32'(busy), 32'd1);
    do_reset();
    @(negedge clk);
    check_val("clr_rst_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
`else
    // Without the clear feature, clear_req has no effect.
    clear_req = 1'b1;
    repeat (3) gap();
    clear_req = 1'b0;
    check_val("noclr_busy", 32'(busy), 32'd0);
`endif

    // Reset mid-frame abandons the frame.
    for (int i = 0; i < 50; i++) send_pixel(8'hFF, i == 0);
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hFF, 1'b0, a);
    s_valid = 1'b0;
    repeat (3) gap();

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    check_val("frame_count", 32'(got_frames), 32'(exp_frames));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

endmodule
